// File: rtl/seg7_scan_mux_pkg.sv
// Shared definitions for the seven-segment scan multiplexer: scan state
// encoding and the active-low glyph set, segment order {g,f,e,d,c,b,a}.
package seg7_scan_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_ON    = 2'd2
  } state_e;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Standard hex glyphs 0..F, active low.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_sseg
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_GLYPH[hex_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for N_DIGITS seven-segment digits. Each digit owns
// a slot of DIV cycles whose first GUARD cycles keep the anode off to avoid
// ghosting. Display data is snapshotted once per frame so a frame never
// mixes old and new values. Every output is decoded from registered state.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter  int N_DIGITS = 8,
  parameter  int DIV      = 100000,
  parameter  int GUARD    = 1000,
  localparam int DW       = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [DW-1:0]         digit_sel,
  output logic                  digit_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [DW-1:0] IDX_LAST = DW'(N_DIGITS - 1);
  // Slot entry state: with no guard time the anode lights immediately.
  localparam state_e SLOT_ENTRY = (GUARD == 0) ? S_ON : S_GUARD;

  // Reject illegal parameter sets at elaboration.
  if (N_DIGITS < 2 || N_DIGITS > 16) begin : g_bad_n_digits
    $error("seg7_scan_mux: N_DIGITS must be in 2..16");
  end
  if (DIV < 2) begin : g_bad_div
    $error("seg7_scan_mux: DIV must be at least 2");
  end
  if (GUARD < 0 || GUARD >= DIV) begin : g_bad_guard
    $error("seg7_scan_mux: GUARD must satisfy 0 <= GUARD < DIV");
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [DW-1:0]         idx_q,   idx_d;
  logic [4*N_DIGITS-1:0] hex_q,   hex_d;
  logic [N_DIGITS-1:0]   dp_q,    dp_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d;

  logic [3:0] cur_nibble;
  logic [6:0] cur_glyph;

  // Next-state logic for scan state, slot counter, digit index and snapshot.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hex_d   = hex_q;
    dp_d    = dp_q;
    blank_d = blank_q;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d = SLOT_ENTRY;
      cnt_d   = '0;
      idx_d   = '0;
      hex_d   = hex_in;
      dp_d    = dp_in;
      blank_d = blank_in;
    end else if (cnt_q == CNT_LAST) begin
      state_d = SLOT_ENTRY;
      cnt_d   = '0;
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        hex_d   = hex_in;
        dp_d    = dp_in;
        blank_d = blank_in;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_d < GUARD_C) ? S_GUARD : S_ON;
    end
  end

  // State and snapshot registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the snapshot is a handful of flops, not a memory, so it is reset to give a defined first frame.
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
    end
  end

  assign cur_nibble = hex_q[{idx_q, 2'b00} +: 4];

  hex_to_sseg u_hex_to_sseg (
    .hex_i (cur_nibble),
    .seg_o (cur_glyph)
  );

  // Segment and decimal-point drive: dark when idle or when the digit is blanked.
  always_comb begin
    seg = SEG_BLANK;
    dp  = 1'b1;
    if (state_q != S_IDLE && !blank_q[idx_q]) begin
      seg = cur_glyph;
      dp  = ~dp_q[idx_q];
    end
  end

  assign digit_sel   = idx_q;
  assign digit_en    = (state_q == S_ON);
  assign frame_start = (state_q != S_IDLE) && (idx_q == '0) && (cnt_q == '0);

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with N_DIGITS=4, DIV=4, GUARD=1.
// Each output cycle is compared as a packed bundle
// {digit_sel[1:0], digit_en, seg[6:0], dp, frame_start} against a
// per-frame table of 16 hand-built expected records.
module tb_seg7_scan_mux;

  localparam int N  = 4;
  localparam int DV = 4;
  localparam int GD = 1;

  typedef struct packed {
    logic [1:0] sel;
    logic       den;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [15:0]   hex_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic [1:0]    digit_sel;
  logic          digit_en;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  int checks   = 0;
  int failures = 0;

  vec_t tbl_a [16];   // hex 1A80, no dp, no blank
  vec_t tbl_b [16];   // hex FFFF, no dp, no blank
  vec_t tbl_c [16];   // hex FFFF, dp_in 0010, blank_in 0100
  vec_t idle_v;

  seg7_scan_mux #(.N_DIGITS(N), .DIV(DV), .GUARD(GD)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .hex_in      (hex_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .digit_sel   (digit_sel),
    .digit_en    (digit_en),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t actual();
    vec_t v;
    v.sel = digit_sel;
    v.den = digit_en;
    v.seg = seg;
    v.dp  = dp;
    v.fs  = frame_start;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got sel=%0d en=%b seg=%h dp=%b fs=%b, required sel=%0d en=%b seg=%h dp=%b fs=%b",
               name, idx, act.sel, act.den, act.seg, act.dp, act.fs,
               exp.sel, exp.den, exp.seg, exp.dp, exp.fs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build one frame's expected outputs from per-digit glyphs and dp/blank masks.
  task automatic fill(input int which, input logic [6:0] g0, input logic [6:0] g1,
                      input logic [6:0] g2, input logic [6:0] g3,
                      input logic [3:0] dpm, input logic [3:0] blm);
    logic [6:0] g [4];
    vec_t v;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        v.sel = 2'(d);
        v.den = (c >= GD);
        v.seg = blm[d] ? 7'h7F : g[d];
        v.dp  = blm[d] ? 1'b1 : ~dpm[d];
        v.fs  = (d == 0 && c == 0);
        case (which)
          0:       tbl_a[d*4+c] = v;
          1:       tbl_b[d*4+c] = v;
          default: tbl_c[d*4+c] = v;
        endcase
      end
    end
  endtask

  // Advance one cycle per entry and compare against the chosen table.
  task automatic run(input string name, input int which, input int first, input int last);
    vec_t e;
    for (int k = first; k <= last; k++) begin
      tick();
      case (which)
        0:       e = tbl_a[k];
        1:       e = tbl_b[k];
        default: e = tbl_c[k];
      endcase
      check(name, k, actual(), e);
    end
  endtask

  initial begin
    fill(0, 7'h40, 7'h00, 7'h08, 7'h79, 4'b0000, 4'b0000);
    fill(1, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b0000, 4'b0000);
    fill(2, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b0010, 4'b0100);
    idle_v = '{sel: 2'd0, den: 1'b0, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

    // Reset held two cycles with en already high: outputs must stay idle.
    reset    = 1'b1;
    en       = 1'b1;
    hex_in   = 16'h1A80;
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
    tick(); check("reset", 0, actual(), idle_v);
    tick(); check("reset", 1, actual(), idle_v);

    // Release: first frame_start one cycle after en is sampled; two full frames.
    reset = 1'b0;
    run("scan_a_f1", 0, 0, 15);
    run("scan_a_f2", 0, 0, 15);

    // Change hex during digit 1's slot: current frame must not change.
    run("hold_a", 0, 0, 4);
    hex_in = 16'hFFFF;
    run("hold_a", 0, 5, 15);
    run("reload_b", 1, 0, 0);

    // New dp/blank masks mid-frame take effect only on the next frame.
    dp_in    = 4'b0010;
    blank_in = 4'b0100;
    run("reload_b", 1, 1, 15);
    run("dp_blank_c", 2, 0, 15);

    // Drop en at cnt=2 of digit 2.
    run("en_drop_c", 2, 0, 10);
    en = 1'b0;
    tick(); check("en_low_idle", 0, actual(), idle_v);
    hex_in   = 16'h1A80;
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
    tick(); check("en_low_idle", 1, actual(), idle_v);
    en = 1'b1;
    run("restart_a", 0, 0, 15);

    // Reset pulse while digit 3 is lit.
    run("pre_reset_a", 0, 0, 13);
    reset = 1'b1;
    tick(); check("mid_reset", 0, actual(), idle_v);
    reset = 1'b0;
    run("resume_a", 0, 0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
